amt_recovery_ctrl: RTL and testbench
====================================

Name: amt_recovery_ctrl

Overview:
- Sequences rename-state recovery after a pipeline rollback (branch mispredict or exception flush).
- On a rollback request it stalls dispatch and waits for retirement writes into the architectural map table to settle.
- It then copies every architectural-map entry into the speculative map table, a fixed number of entries per cycle, and pulses free-list rebuild and done.
- Sits between the ROB rollback signal, the architectural map table, the speculative map table write port and dispatch.

Parameters:
- C_MT_ENTRY, 32, number of architectural registers (map table entries).
- C_TAG_IDX_WIDTH, 6, physical tag width.
- C_ARCH_IDX_WIDTH, 5, architectural index width, equal to clog2(C_MT_ENTRY).
- C_COPY_WIDTH, 4, entries copied per beat, 1..C_MT_ENTRY; need not divide C_MT_ENTRY.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- rollback_i  in  1  single-cycle rollback request from ROB.
- rt_busy_i  in  1  retire is writing the architectural map this cycle.
- amt_tag_i  in  C_MT_ENTRY*C_TAG_IDX_WIDTH  architectural map tags; entry i occupies bits [i*W +: W].
- stall_dp_o  out  1  dispatch stall.
- busy_o  out  1  recovery in progress (state != IDLE).
- mt_wr_en_o  out  C_COPY_WIDTH  per-lane speculative map write enable.
- mt_wr_idx_o  out  C_COPY_WIDTH*C_ARCH_IDX_WIDTH  per-lane entry index.
- mt_wr_tag_o  out  C_COPY_WIDTH*C_TAG_IDX_WIDTH  per-lane tag.
- fl_rebuild_o  out  1  one-cycle pulse telling the free list to rebuild from the architectural map.
- recovery_done_o  out  1  one-cycle completion pulse.

Behaviour:
- Single clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE, beat counter = 0.
  - All outputs 0.
- States: IDLE, SETTLE, COPY, DONE. B = ceil(C_MT_ENTRY / C_COPY_WIDTH) beats.
- IDLE:
  - rollback_i=1 moves to SETTLE next cycle.
  - stall_dp_o = rollback_i, combinational, so the same-cycle dispatch is blocked.
- SETTLE:
  - Holds while rt_busy_i=1.
  - rt_busy_i=0 moves to COPY with beat=0.
  - Minimum one cycle, so the last registered map write is visible on amt_tag_i.
- COPY, each cycle:
  - Lane k: idx = beat*C_COPY_WIDTH + k.
  - wr_en[k] = (idx < C_MT_ENTRY).
  - wr_idx[k] = idx truncated to C_ARCH_IDX_WIDTH.
  - wr_tag[k] = amt_tag_i entry idx, read live.
  - Lanes with wr_en=0 drive idx=0 and tag=0.
  - beat increments each cycle. After beat B-1 the next state is DONE.
  - Write outputs are combinational from state and beat. They are 0 in every state except COPY.
- DONE:
  - fl_rebuild_o=1 and recovery_done_o=1 for exactly this cycle.
  - Next state is IDLE.
- stall_dp_o = rollback_i OR (state != IDLE). It is high through DONE and drops in the first IDLE cycle.
- busy_o = (state != IDLE).
- Timing with defaults, rollback at cycle T and rt_busy_i=0:
  - SETTLE at T+1.
  - COPY at T+2..T+9 (B=8).
  - DONE at T+10.
  - IDLE at T+11.
- Simultaneous and boundary events:
  - rollback_i in SETTLE: no change, remains SETTLE.
  - rollback_i in COPY or DONE: abort and go to SETTLE next cycle with beat reset to 0.
  - An aborted DONE cycle still shows its done and rebuild pulses (outputs are from current state), but the restart guarantees a full copy follows. The verifier must accept this.
  - rt_busy_i high during COPY is a protocol violation. Assert in simulation; no RTL handling.
  - Asynchronous reset mid-operation returns immediately to IDLE. All outputs go 0 in the same cycle, with no done pulse.
- Beat counter width is clog2(B+1). No wrap is possible, because the counter leaves COPY at B-1.

Test Plan:
- Reset then idle: assert rst_i mid-cycle -> all outputs 0 immediately. 20 idle cycles -> no writes, stall_dp_o=0.
- Basic recovery: amt_tag_i entry i = i+32, rollback at T, rt_busy_i=0 -> beat 0 at T+2 writes idx 0..3 with tags 32..35; beat 7 at T+9 writes idx 28..31 with tags 60..63; done and rebuild pulse at T+10; stall high on T..T+10 and low at T+11.
- Retire drain: rollback at T with rt_busy_i high T+1..T+3 -> SETTLE held; first COPY beat at T+5; done at T+13.
- Non-dividing width, C_COPY_WIDTH=5 and C_MT_ENTRY=32: B=7 -> last beat has wr_en=5'b00011, idx 30 and 31, lanes 2..4 drive idx=0 and tag=0.
- Rollback during COPY at beat 3 -> next cycle SETTLE; copy restarts at beat 0; exactly one done pulse, at the end of the restarted copy.
- Asynchronous reset at COPY beat 4 -> wr_en=0 and stall=0 at once; no done pulse; a subsequent rollback performs a full 8-beat copy.

Source files
------------

// File: rtl/amt_recovery_ctrl_if.sv
// Connection bundle between ROB rollback, architectural/speculative map tables and dispatch
// for the rename-state recovery sequencer.
interface amt_recovery_ctrl_if #(
  parameter int unsigned C_MT_ENTRY       = 32,
  parameter int unsigned C_TAG_IDX_WIDTH  = 6,
  parameter int unsigned C_ARCH_IDX_WIDTH = 5,
  parameter int unsigned C_COPY_WIDTH     = 4
);
  logic                                       rollback_i;
  logic                                       rt_busy_i;
  logic [C_MT_ENTRY*C_TAG_IDX_WIDTH-1:0]      amt_tag_i;
  logic                                       stall_dp_o;
  logic                                       busy_o;
  logic [C_COPY_WIDTH-1:0]                    mt_wr_en_o;
  logic [C_COPY_WIDTH*C_ARCH_IDX_WIDTH-1:0]   mt_wr_idx_o;
  logic [C_COPY_WIDTH*C_TAG_IDX_WIDTH-1:0]    mt_wr_tag_o;
  logic                                       fl_rebuild_o;
  logic                                       recovery_done_o;

  modport master (
    output rollback_i, rt_busy_i, amt_tag_i,
    input  stall_dp_o, busy_o, mt_wr_en_o, mt_wr_idx_o, mt_wr_tag_o, fl_rebuild_o,
           recovery_done_o
  );

  modport slave (
    input  rollback_i, rt_busy_i, amt_tag_i,
    output stall_dp_o, busy_o, mt_wr_en_o, mt_wr_idx_o, mt_wr_tag_o, fl_rebuild_o,
           recovery_done_o
  );
endinterface

// File: rtl/amt_recovery_ctrl.sv
// Rename-state recovery sequencer: after a rollback, waits for retire to settle, then copies
// the architectural map into the speculative map C_COPY_WIDTH entries per cycle.
module amt_recovery_ctrl #(
  parameter int unsigned C_MT_ENTRY       = 32,
  parameter int unsigned C_TAG_IDX_WIDTH  = 6,
  parameter int unsigned C_ARCH_IDX_WIDTH = 5,
  parameter int unsigned C_COPY_WIDTH     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  amt_recovery_ctrl_if.slave    bus
);

  localparam int unsigned Beats = (C_MT_ENTRY + C_COPY_WIDTH - 1) / C_COPY_WIDTH;
  localparam int unsigned BeatW = $clog2(Beats + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCopy, StDone} state_e;

  state_e           state_q;
  logic [BeatW-1:0] beat_q;
  logic             busy;

  logic [C_COPY_WIDTH-1:0]                  wr_en;
  logic [C_COPY_WIDTH*C_ARCH_IDX_WIDTH-1:0] wr_idx;
  logic [C_COPY_WIDTH*C_TAG_IDX_WIDTH-1:0]  wr_tag;
  logic [31:0]                              lane_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.rollback_i) state_q <= StSettle;
        end
        // Always spend at least one cycle here so the last retire write lands in amt_tag_i.
        StSettle: begin
          if (!bus.rt_busy_i) begin
            state_q <= StCopy;
            beat_q  <= '0;
          end
        end
        StCopy: begin
          if (bus.rollback_i) begin
            state_q <= StSettle;
            beat_q  <= '0;
          end else if (beat_q == LastBeat) begin
            state_q <= StDone;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        StDone: begin
          beat_q  <= '0;
          state_q <= bus.rollback_i ? StSettle : StIdle;
        end
        default: begin
          state_q <= StIdle;
          beat_q  <= '0;
        end
      endcase
    end
  end

  // Copy lanes read the architectural map live; lanes past the last entry stay all-zero.
  always_comb begin
    wr_en    = '0;
    wr_idx   = '0;
    wr_tag   = '0;
    lane_idx = '0;
    if (state_q == StCopy) begin
      for (int unsigned k = 0; k < C_COPY_WIDTH; k++) begin
        lane_idx = 32'(beat_q) * C_COPY_WIDTH + k;
        if (lane_idx < C_MT_ENTRY) begin
          wr_en[k] = 1'b1;
          wr_idx[k*C_ARCH_IDX_WIDTH +: C_ARCH_IDX_WIDTH] = C_ARCH_IDX_WIDTH'(lane_idx);
          wr_tag[k*C_TAG_IDX_WIDTH +: C_TAG_IDX_WIDTH] =
            bus.amt_tag_i[lane_idx*C_TAG_IDX_WIDTH +: C_TAG_IDX_WIDTH];
        end
      end
    end
  end

  assign busy                = (state_q != StIdle);
  assign bus.busy_o          = busy;
  assign bus.stall_dp_o      = bus.rollback_i | busy;
  assign bus.mt_wr_en_o      = wr_en;
  assign bus.mt_wr_idx_o     = wr_idx;
  assign bus.mt_wr_tag_o     = wr_tag;
  assign bus.fl_rebuild_o    = (state_q == StDone);
  assign bus.recovery_done_o = (state_q == StDone);

  // Retire must be quiet while the copy reads the architectural map.
  a_no_retire_in_copy: assert property (
    @(posedge clk_i) disable iff (rst_i) (state_q == StCopy) |-> !bus.rt_busy_i
  ) else $error("rt_busy_i asserted during map copy");

endmodule

// File: tb/tb_amt_recovery_ctrl.sv
// Scoreboard bench: two sequencers (4 and 5 lanes per beat) share stimulus; a reference model
// predicts copy beats and done pulses per cycle, a monitor pops and compares them.
module tb_amt_recovery_ctrl;
  localparam int N = 32;

  typedef struct packed {
    int          cycle;
    logic        done;
    logic [7:0]  en;
    logic [39:0] idx;
    logic [47:0] tag;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rollback;
  logic       rt_busy;
  logic [5:0] amt [N];
  logic [N*6-1:0] amt_flat;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  done_cnt [2];
  int  beat_cnt [2];
  ev_t q0 [$];
  ev_t q1 [$];

  // Reference state: whether a recovery is in flight, whether copying has begun, and the
  // first map entry to be copied in the current cycle.
  bit  m_busy    [2];
  bit  m_settled [2];
  int  m_next    [2];
  bit  exp_stall [2];
  bit  exp_busy  [2];

  amt_recovery_ctrl_if #(.C_COPY_WIDTH(4)) if0 ();
  amt_recovery_ctrl_if #(.C_COPY_WIDTH(5)) if1 ();

  assign if0.rollback_i = rollback;
  assign if0.rt_busy_i  = rt_busy;
  assign if0.amt_tag_i  = amt_flat;
  assign if1.rollback_i = rollback;
  assign if1.rt_busy_i  = rt_busy;
  assign if1.amt_tag_i  = amt_flat;

  always_comb begin
    amt_flat = '0;
    for (int i = 0; i < N; i++) amt_flat[i*6 +: 6] = amt[i];
  end

  amt_recovery_ctrl #(.C_COPY_WIDTH(4)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  amt_recovery_ctrl #(.C_COPY_WIDTH(5)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit any_copy();
    for (int d = 0; d < 2; d++)
      if (m_busy[d] && m_settled[d] && m_next[d] < N) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input int d);
    int  cw;
    int  ent;
    ev_t e;
    cw = (d == 0) ? 4 : 5;
    if (rst) begin
      m_busy[d] = 0; m_settled[d] = 0; m_next[d] = 0;
      exp_busy[d] = 0; exp_stall[d] = rollback;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    exp_busy[d]  = m_busy[d];
    exp_stall[d] = rollback | m_busy[d];
    if (m_busy[d] && m_settled[d]) begin
      e = '0;
      e.cycle = cyc;
      e.done  = (m_next[d] >= N);
      if (!e.done) begin
        for (int k = 0; k < cw; k++) begin
          ent = m_next[d] + k;
          if (ent < N) begin
            e.en[k] = 1'b1;
            e.idx[k*5 +: 5] = 5'(ent);
            e.tag[k*6 +: 6] = amt[ent];
          end
        end
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    // Advance to the following cycle.
    if (!m_busy[d]) begin
      if (rollback) begin m_busy[d] = 1; m_settled[d] = 0; end
    end else if (!m_settled[d]) begin
      if (!rt_busy) begin m_settled[d] = 1; m_next[d] = 0; end
    end else if (m_next[d] < N) begin
      if (rollback) m_settled[d] = 0;
      else m_next[d] = m_next[d] + cw;
    end else begin
      if (rollback) m_settled[d] = 0;
      else begin m_busy[d] = 0; m_settled[d] = 0; end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic mon_one(input int d, input logic [7:0] en, input logic [39:0] idx,
                         input logic [47:0] tag, input logic done, input logic reb,
                         input logic stall, input logic busy);
    bit  presented;
    bit  have;
    ev_t e;
    presented = (en != 0) || done || reb;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (done) done_cnt[d]++;
    if (en != 0) beat_cnt[d]++;
    chk($sformatf("dut%0d_stall", d), stall, exp_stall[d]);
    chk($sformatf("dut%0d_busy", d), busy, exp_busy[d]);
    if (presented) begin
      chk($sformatf("dut%0d_unexpected_output", d), have, 1);
      if (have) begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("dut%0d_event_cycle", d), cyc, e.cycle);
        chk($sformatf("dut%0d_wr_en", d), en, e.en);
        chk($sformatf("dut%0d_wr_idx", d), idx, e.idx);
        chk($sformatf("dut%0d_wr_tag", d), tag, e.tag);
        chk($sformatf("dut%0d_done", d), done, e.done);
        chk($sformatf("dut%0d_rebuild", d), reb, e.done);
      end
    end else if (have) begin
      if (d == 0) e = q0[0]; else e = q1[0];
      if (e.cycle <= cyc) begin
        chk($sformatf("dut%0d_missing_output", d), presented, 1);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    mon_one(0, 8'(if0.mt_wr_en_o), 40'(if0.mt_wr_idx_o), 48'(if0.mt_wr_tag_o),
            if0.recovery_done_o, if0.fl_rebuild_o, if0.stall_dp_o, if0.busy_o);
    mon_one(1, 8'(if1.mt_wr_en_o), 40'(if1.mt_wr_idx_o), 48'(if1.mt_wr_tag_o),
            if1.recovery_done_o, if1.fl_rebuild_o, if1.stall_dp_o, if1.busy_o);
  end

  task automatic drive(input bit rb, input bit rtb);
    @(posedge clk);
    #1;
    rollback = rb;
    rt_busy  = rtb & !any_copy();
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_en0"}, if0.mt_wr_en_o, 0);
    chk({name, "_idx0"}, if0.mt_wr_idx_o, 0);
    chk({name, "_tag0"}, if0.mt_wr_tag_o, 0);
    chk({name, "_stall0"}, if0.stall_dp_o, 0);
    chk({name, "_busy0"}, if0.busy_o, 0);
    chk({name, "_done0"}, if0.recovery_done_o | if0.fl_rebuild_o, 0);
    chk({name, "_en1"}, if1.mt_wr_en_o, 0);
    chk({name, "_stall1"}, if1.stall_dp_o | if1.busy_o, 0);
  endtask

  // Reset asserted shortly after a clock edge, held through one full cycle.
  task automatic reset_mid();
    @(posedge clk);
    #1;
    rst = 1'b1; rollback = 1'b0; rt_busy = 1'b0;
    #1;
    check_quiet("reset_immediate");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    int b0;
    rst = 1'b1; rollback = 1'b0; rt_busy = 1'b0;
    for (int i = 0; i < N; i++) amt[i] = 6'(i + 32);
    done_cnt[0] = 0; done_cnt[1] = 0; beat_cnt[0] = 0; beat_cnt[1] = 0;
    #1;
    check_quiet("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    reset_mid();
    b0 = beat_cnt[0];
    repeat (20) drive(0, 0);
    chk("idle_no_writes", beat_cnt[0] - b0, 0);

    // Basic recovery, tags i+32.
    d0 = done_cnt[0]; b0 = beat_cnt[0];
    drive(1, 0);
    repeat (12) drive(0, 0);
    chk("basic_beats", beat_cnt[0] - b0, 8);
    chk("basic_done", done_cnt[0] - d0, 1);

    // Retire drain keeps the sequencer settling.
    drive(1, 0);
    repeat (3) drive(0, 1);
    repeat (12) drive(0, 0);

    // Rollback at copy beat 3 restarts the copy.
    d0 = done_cnt[0]; b0 = beat_cnt[0];
    drive(1, 0);
    repeat (4) drive(0, 0);
    drive(1, 0);
    repeat (14) drive(0, 0);
    chk("abort_single_done", done_cnt[0] - d0, 1);
    chk("abort_beats", beat_cnt[0] - b0, 4 + 8);

    // Reset at copy beat 4, then a full recovery.
    d0 = done_cnt[0];
    drive(1, 0);
    repeat (5) drive(0, 0);
    reset_mid();
    drive(0, 0);
    chk("reset_no_done", done_cnt[0] - d0, 0);
    b0 = beat_cnt[0];
    drive(1, 0);
    repeat (12) drive(0, 0);
    chk("post_reset_beats", beat_cnt[0] - b0, 8);
    chk("post_reset_done", done_cnt[0] - d0, 1);

    // Random traffic with live map updates.
    repeat (800) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_mid();
      end else begin
        if ($urandom_range(0, 3) == 0) amt[$urandom_range(0, N-1)] = 6'($urandom);
        drive($urandom_range(0, 14) == 0, $urandom_range(0, 2) == 0);
      end
    end

    repeat (15) drive(0, 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
